sqrt_batch_seq: RTL and testbench

Batch controller that sequences the 16-entry 8-bit operand RAM through the square-root unit. On a `go` command it walks RAM addresses 0..`last_addr`, feeds each operand to the square-root unit with a start pulse, and waits for completion. It then writes each root into result storage at the same address. It replaces the ad-hoc "increment address on Done" logic in the lab top level and owns the RAM read address whenever `busy` is high.

---
 rtl/sqrt_seq_pkg.sv | 21 ++
 rtl/sqrt_batch_seq.sv | 168 ++++++++++++++++
 tb/tb_sqrt_batch_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_seq_pkg.sv
// Shared constants for the square-root batch sequencer: state encodings,
// default widths and the value written for an operand that timed out.
package sqrt_seq_pkg;

   localparam int unsigned AW_DEF = 4;
   localparam int unsigned DW_DEF = 8;
   localparam int unsigned CW     = 8;

   localparam logic [7:0] ERR_RESULT = 8'hFF;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_FETCH  = 3'd1;
   localparam state_t S_LATCH  = 3'd2;
   localparam state_t S_START  = 3'd3;
   localparam state_t S_WAIT   = 3'd4;
   localparam state_t S_STORE  = 3'd5;
   localparam state_t S_FINISH = 3'd6;

endpackage

// File: rtl/sqrt_batch_seq.sv
// Walks operand RAM addresses 0..last_addr through the square-root unit and
// writes each root (or ERR_RESULT on timeout) back at the same address.
module sqrt_batch_seq
   import sqrt_seq_pkg::*;
#(
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          resetN,
   input  logic          go,
   input  logic          abort,
   input  logic [AW-1:0] last_addr,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_rd_data,
   output logic [DW-1:0] sq_N,
   output logic          sq_St,
   input  logic          sq_Done,
   input  logic [DW-1:0] sq_Sqrt,
   output logic          res_wr,
   output logic [AW-1:0] res_addr,
   output logic [DW-1:0] res_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] err_addr
);

   state_t        r_state,    w_state;
   logic [AW-1:0] r_addr,     w_addr;
   logic [AW-1:0] r_last,     w_last;
   logic [DW-1:0] r_sq_n,     w_sq_n;
   logic          r_st,       w_st;
   logic [CW-1:0] r_cnt,      w_cnt;
   logic          r_res_wr,   w_res_wr;
   logic [DW-1:0] r_res_data, w_res_data;
   logic          r_busy,     w_busy;
   logic          r_done,     w_done;
   logic          r_err,      w_err;
   logic [AW-1:0] r_err_addr, w_err_addr;
   logic          r_done_prev;

   logic          w_done_edge;
   logic [CW-1:0] w_cnt_inc;

   // Only a fresh rising edge of sq_Done counts; a level left over from the
   // previous operand must not complete the current one.
   assign w_done_edge = sq_Done & ~r_done_prev;
   assign w_cnt_inc   = r_cnt + CW'(1);

   always_comb begin
      w_state    = r_state;
      w_addr     = r_addr;
      w_last     = r_last;
      w_sq_n     = r_sq_n;
      w_st       = 1'b0;
      w_cnt      = r_cnt;
      w_res_wr   = 1'b0;
      w_res_data = r_res_data;
      w_done     = 1'b0;
      w_err      = r_err;
      w_err_addr = r_err_addr;

      case (r_state)
         S_IDLE: begin
            if (go && !abort) begin
               w_state    = S_FETCH;
               w_addr     = '0;
               w_last     = last_addr;
               w_err      = 1'b0;
               w_err_addr = '0;
            end
         end
         S_FETCH: w_state = S_LATCH;
         S_LATCH: begin
            w_sq_n  = ram_rd_data;
            w_st    = 1'b1;
            w_state = S_START;
         end
         S_START: begin
            w_cnt   = '0;
            w_state = S_WAIT;
         end
         S_WAIT: begin
            w_cnt = w_cnt_inc;
            if (w_done_edge) begin
               w_res_data = sq_Sqrt;
               w_res_wr   = 1'b1;
               w_state    = S_STORE;
            end else if (w_cnt_inc == CW'(TIMEOUT)) begin
               w_res_data = DW'(ERR_RESULT);
               w_res_wr   = 1'b1;
               w_state    = S_STORE;
               if (!r_err) begin
                  w_err      = 1'b1;
                  w_err_addr = r_addr;
               end
            end
         end
         S_STORE: begin
            if (r_addr == r_last) begin
               w_done  = 1'b1;
               w_state = S_FINISH;
            end else begin
               w_addr  = r_addr + AW'(1);
               w_state = S_FETCH;
            end
         end
         S_FINISH: w_state = S_IDLE;
         default:  w_state = S_IDLE;
      endcase

      // Abort overrides everything except the sticky error record.
      if (abort && (r_state != S_IDLE)) begin
         w_state  = S_IDLE;
         w_st     = 1'b0;
         w_res_wr = 1'b0;
         w_done   = 1'b0;
      end

      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_last      <= '0;
         r_sq_n      <= '0;
         r_st        <= 1'b0;
         r_cnt       <= '0;
         r_res_wr    <= 1'b0;
         r_res_data  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_addr  <= '0;
         r_done_prev <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_addr      <= w_addr;
         r_last      <= w_last;
         r_sq_n      <= w_sq_n;
         r_st        <= w_st;
         r_cnt       <= w_cnt;
         r_res_wr    <= w_res_wr;
         r_res_data  <= w_res_data;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_err       <= w_err;
         r_err_addr  <= w_err_addr;
         r_done_prev <= sq_Done;
      end
   end

   assign ram_addr = r_addr;
   assign res_addr = r_addr;
   assign sq_N     = r_sq_n;
   assign sq_St    = r_st;
   assign res_wr   = r_res_wr;
   assign res_data = r_res_data;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;
   assign err_addr = r_err_addr;

endmodule

// File: tb/tb_sqrt_batch_seq.sv
// Scoreboard bench for sqrt_batch_seq: a RAM and square-root unit model feed
// the DUT; expected writes are queued by stimulus and popped by a monitor.
module tb_sqrt_batch_seq;

   localparam int TO = 10;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       go = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] last_addr = '0;
   logic [3:0] ram_addr;
   logic [7:0] ram_rd_data = '0;
   logic [7:0] sq_N;
   logic       sq_St;
   logic       sq_Done = 1'b0;
   logic [7:0] sq_Sqrt = '0;
   logic       res_wr;
   logic [3:0] res_addr;
   logic [7:0] res_data;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] err_addr;

   sqrt_batch_seq #(.AW(4), .DW(8), .TIMEOUT(TO)) dut (
      .clk(clk), .resetN(resetN), .go(go), .abort(abort), .last_addr(last_addr),
      .ram_addr(ram_addr), .ram_rd_data(ram_rd_data), .sq_N(sq_N), .sq_St(sq_St),
      .sq_Done(sq_Done), .sq_Sqrt(sq_Sqrt), .res_wr(res_wr), .res_addr(res_addr),
      .res_data(res_data), .busy(busy), .done(done), .err(err), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int go_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int wr_cnt = 0;
   int st_cnt = 0;
   logic [11:0] sb[$];

   logic [7:0] mem[16];

   int         m_lat = 5;
   bit         m_hold = 1'b0;
   bit         m_silent = 1'b0;
   logic [7:0] m_silent_n = '0;
   int         m_rem = 0;
   logic       m_pend = 1'b0;
   logic [7:0] m_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] isqrt(input logic [7:0] n);
      int r = 0;
      while ((r + 1) * (r + 1) <= int'(n)) r++;
      return 8'(r);
   endfunction

   // Synchronous-read operand RAM.
   always @(posedge clk) ram_rd_data <= mem[ram_addr];

   // Square-root unit: answers L cycles after the start pulse it samples.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sq_Done <= 1'b0;
         sq_Sqrt <= '0;
         m_pend  <= 1'b0;
         m_rem   <= 0;
      end else if (sq_St) begin
         if (m_silent && sq_N == m_silent_n) begin
            m_pend  <= 1'b0;
            sq_Done <= 1'b0;
         end else if (m_lat <= 1) begin
            sq_Done <= 1'b1;
            sq_Sqrt <= isqrt(sq_N);
            m_pend  <= 1'b0;
         end else begin
            m_pend <= 1'b1;
            m_rem  <= m_lat - 1;
            m_res  <= isqrt(sq_N);
            if (!m_hold) sq_Done <= 1'b0;
         end
      end else if (m_pend) begin
         if (m_rem == 1) begin
            sq_Done <= 1'b1;
            sq_Sqrt <= m_res;
            m_pend  <= 1'b0;
         end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) sq_Done <= 1'b0;
         end
      end
   end

   // Monitor: pops an expected write for every res_wr strobe.
   always @(negedge clk) begin
      if (resetN) begin
         if (res_wr) begin
            wr_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d data %0d required none", res_addr, res_data);
            end else begin
               logic [11:0] e;
               e = sb.pop_front();
               chk("wr_addr", 32'(res_addr), 32'(e[11:8]));
               chk("wr_data", 32'(res_data), 32'(e[7:0]));
            end
         end
         if (sq_St) st_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push(input logic [3:0] a, input logic [7:0] d);
      sb.push_back({a, d});
   endtask

   task automatic start_batch(input logic [3:0] la);
      @(negedge clk);
      last_addr = la;
      go        = 1'b1;
      go_cyc    = cyc;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
      if (done_cnt == d0) chk("done_timeout", 0, 1);
   endtask

   task automatic wait_rel(input int c);
      while (cyc - go_cyc < c) @(negedge clk);
   endtask

   task automatic load_squares();
      mem[0] = 8'd1; mem[1] = 8'd4; mem[2] = 8'd9; mem[3] = 8'd16;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st0, wr0, d0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      load_squares();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_strobes", 32'({sq_St, res_wr}), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      resetN = 1'b1;

      // Basic batch, L=5
      m_lat = 5;
      push(4'd0, 8'd1); push(4'd1, 8'd2); push(4'd2, 8'd3); push(4'd3, 8'd4);
      start_batch(4'd3);
      chk("t1_busy", 32'(busy), 1);
      wait_done(200);
      chk("t1_done_cycle", 32'(done_cyc - go_cyc), 37);
      @(negedge clk);
      chk("t1_busy_after", 32'(busy), 0);
      chk("t1_err", 32'(err), 0);
      chk("t1_sb_empty", 32'(sb.size()), 0);

      // Done held high between operands
      m_hold = 1'b1;
      st0 = st_cnt; wr0 = wr_cnt;
      push(4'd0, 8'd1); push(4'd1, 8'd2); push(4'd2, 8'd3); push(4'd3, 8'd4);
      start_batch(4'd3);
      wait_done(200);
      chk("t2_done_cycle", 32'(done_cyc - go_cyc), 37);
      chk("t2_st_count", 32'(st_cnt - st0), 4);
      chk("t2_wr_count", 32'(wr_cnt - wr0), 4);
      m_hold = 1'b0;

      // Timeout at addr 2
      m_lat = 3; m_silent = 1'b1; m_silent_n = 8'd9;
      push(4'd0, 8'd1); push(4'd1, 8'd2); push(4'd2, 8'hFF); push(4'd3, 8'd4);
      start_batch(4'd3);
      wait_done(200);
      chk("t3_done_cycle", 32'(done_cyc - go_cyc), 36);
      @(negedge clk);
      chk("t3_err", 32'(err), 1);
      chk("t3_err_addr", 32'(err_addr), 2);
      m_silent = 1'b0;

      // Abort in WAIT at addr 1, then restart
      m_lat = 5;
      d0 = done_cnt; wr0 = wr_cnt;
      push(4'd0, 8'd1);
      start_batch(4'd3);
      chk("t4_err_cleared", 32'(err), 0);
      wait_rel(14);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t4_abort_idle", 32'(busy), 0);
      chk("t4_abort_strobes", 32'({sq_St, res_wr, done}), 0);
      repeat (40) @(negedge clk);
      chk("t4_no_done", 32'(done_cnt - d0), 0);
      chk("t4_wr_count", 32'(wr_cnt - wr0), 1);
      push(4'd0, 8'd1); push(4'd1, 8'd2); push(4'd2, 8'd3); push(4'd3, 8'd4);
      start_batch(4'd3);
      chk("t4_restart_addr", 32'(ram_addr), 0);
      wait_done(200);
      chk("t4_restart_done", 32'(done_cyc - go_cyc), 37);

      // Full 16-entry batch, no wrap
      for (int i = 0; i < 15; i++) mem[i] = 8'(i * i);
      mem[15] = 8'd255;
      m_lat = 2;
      wr0 = wr_cnt;
      for (int i = 0; i < 16; i++) push(4'(i), 8'(i));
      start_batch(4'hF);
      wait_done(400);
      chk("t5_done_cycle", 32'(done_cyc - go_cyc), 97);
      repeat (10) @(negedge clk);
      chk("t5_wr_count", 32'(wr_cnt - wr0), 16);
      chk("t5_busy", 32'(busy), 0);

      // go and last_addr changes while busy are ignored
      load_squares();
      m_lat = 4;
      wr0 = wr_cnt;
      push(4'd0, 8'd1); push(4'd1, 8'd2);
      start_batch(4'd1);
      wait_rel(5);
      go = 1'b1; last_addr = 4'd3;
      @(negedge clk);
      go = 1'b0;
      wait_done(200);
      chk("t6_done_cycle", 32'(done_cyc - go_cyc), 17);
      repeat (20) @(negedge clk);
      chk("t6_wr_count", 32'(wr_cnt - wr0), 2);

      // Reset in WAIT after an error has been recorded
      m_silent = 1'b1; m_silent_n = 8'd1;
      push(4'd0, 8'hFF);
      start_batch(4'd3);
      wait_rel(20);
      chk("t7_err_before", 32'(err), 1);
      chk("t7_busy_before", 32'(busy), 1);
      resetN = 1'b0;
      #1;
      chk("t7_rst_busy", 32'(busy), 0);
      chk("t7_rst_err", 32'(err), 0);
      chk("t7_rst_sq_n", 32'(sq_N), 0);
      chk("t7_rst_addr", 32'({ram_addr, res_addr, err_addr}), 0);
      chk("t7_rst_res_data", 32'(res_data), 0);
      chk("t7_rst_strobes", 32'({sq_St, res_wr, done}), 0);
      chk("t7_sb_empty", 32'(sb.size()), 0);
      sb.delete();
      m_silent = 1'b0;
      @(negedge clk);
      resetN = 1'b1;

      push(4'd0, 8'd1); push(4'd1, 8'd2); push(4'd2, 8'd3); push(4'd3, 8'd4);
      m_lat = 5;
      start_batch(4'd3);
      wait_done(200);
      chk("t8_done_cycle", 32'(done_cyc - go_cyc), 37);
      repeat (5) @(negedge clk);
      chk("t8_sb_empty", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
